// File: rtl/vm1_qbus_pkg.sv
// Shared types and helpers for the vm1 Q-bus demultiplexer.
// The VM1_QBUS_TIMEOUT_EN build option is handled in vm1_qbus_demux.
package vm1_qbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD,
    RDONE,
    RMWW,
    WR,
    WDONE,
    WAITS
  } state_t;

  // Enable for one byte lane: all lanes on word access, addressed lane on byte access
  function automatic logic be_gen(
    input logic       byte_op,
    input logic [5:0] addr_lsbs,
    input int         lane,
    input int         data_w
  );
    int lanes;
    lanes = data_w / 8;
    return !byte_op || (lane == (int'(addr_lsbs) % lanes));
  endfunction

endpackage

// File: rtl/vm1_qbus_edge.sv
// Registered rise/fall detector for the SYNC, DIN and DOUT strobes.
// Bit order: [0]=sync, [1]=din, [2]=dout.
module vm1_qbus_edge (
  input  logic       pin_clk,
  input  logic       pin_dclo_n,
  input  logic [2:0] sig,
  output logic [2:0] rise,
  output logic [2:0] fall
);

  logic [2:0] sig_q;

  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/vm1_qbus_demux.sv
// Q-bus AD/SYNC/DIN/DOUT handshake to flat memory bus demultiplexer.
// Define VM1_QBUS_TIMEOUT_EN to enable the bus-timeout error path.
module vm1_qbus_demux
  import vm1_qbus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 64
) (
  input  logic                pin_clk,
  input  logic                pin_dclo_n,
  input  logic [ADDR_W-1:0]   core_ad_out,
  output logic [ADDR_W-1:0]   core_ad_in,
  input  logic                core_sync,
  input  logic                core_din,
  input  logic                core_dout,
  input  logic                core_wtbt,
  input  logic                core_rmw,
  output logic                core_rply,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack
);

  localparam int BE_W = DATA_W / 8;

  if ((DATA_W % 8) != 0 || TMO_CYC < 1) begin : g_bad_cfg
    $error("vm1_qbus_demux: invalid DATA_W or TMO_CYC");
  end

  state_t            state, state_nx;
  logic [2:0]        rise, fall;
  logic              sync_rise, sync_fall;
  logic              din_rise, din_fall;
  logic              dout_rise, dout_fall;
  logic              rmw_flag, byte_q;
  logic [DATA_W-1:0] rd_data;
  logic              tmo_hit;

  vm1_qbus_edge u_edge (
    .pin_clk    (pin_clk),
    .pin_dclo_n (pin_dclo_n),
    .sig        ({core_dout, core_din, core_sync}),
    .rise       (rise),
    .fall       (fall)
  );

  assign sync_rise = rise[0];
  assign din_rise  = rise[1];
  assign dout_rise = rise[2];
  assign sync_fall = fall[0];
  assign din_fall  = fall[1];
  assign dout_fall = fall[2];

`ifdef VM1_QBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             busy;

  assign busy    = (state == RD) || (state == WR);
  assign tmo_hit = busy && !mem_ack
                && (tmo_cnt == CNT_W'(TMO_CYC - 1));

  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n || !busy) begin
      tmo_cnt <= '0;
    end else if (!mem_ack) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo_hit && !sync_fall;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (sync_rise) state_nx = ADDR;
      ADDR: begin
        if (core_din || din_rise) state_nx = RD;
        else if (core_dout)       state_nx = WR;
        else if (!core_sync)      state_nx = IDLE;
      end
      RD:    if (mem_ack || tmo_hit) state_nx = RDONE;
      RDONE: if (din_fall) state_nx = rmw_flag ? RMWW : WAITS;
      RMWW:  if (dout_rise) state_nx = WR;
      WR:    if (mem_ack || tmo_hit) state_nx = WDONE;
      WDONE: if (dout_fall) state_nx = WAITS;
      WAITS: if (!core_sync) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (sync_fall) state_nx = IDLE;
  end

  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      core_rply <= 1'b0;
      rmw_flag  <= 1'b0;
      byte_q    <= 1'b0;
    end else if (sync_fall) begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      core_rply <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (sync_rise) begin
          mem_addr <= core_ad_out;
          rmw_flag <= core_rmw;
          byte_q   <= 1'b0;
        end
        ADDR: begin
          if (core_din || din_rise) begin
            mem_re <= 1'b1;
          end else if (core_dout) begin
            mem_wdata <= DATA_W'(core_ad_out);
            byte_q    <= core_wtbt;
            mem_we    <= 1'b1;
          end
        end
        // A timed-out read returns zero data
        RD: if (mem_ack || tmo_hit) begin
          rd_data   <= mem_ack ? mem_rdata : '0;
          mem_re    <= 1'b0;
          core_rply <= 1'b1;
        end
        RDONE: if (din_fall) core_rply <= 1'b0;
        RMWW: if (dout_rise) begin
          mem_wdata <= DATA_W'(core_ad_out);
          byte_q    <= core_wtbt;
          mem_we    <= 1'b1;
        end
        WR: if (mem_ack || tmo_hit) begin
          mem_we    <= 1'b0;
          core_rply <= 1'b1;
        end
        WDONE: if (dout_fall) core_rply <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_be = '0;
    for (int i = 0; i < BE_W; i++) begin
      mem_be[i] = be_gen(byte_q, mem_addr[5:0], i, DATA_W);
    end
  end

  assign core_ad_in = core_din ? ADDR_W'(rd_data) : core_ad_out;

endmodule

// File: tb/tb_vm1_qbus_demux.sv
// Self-checking bench for vm1_qbus_demux (22-bit address, 16-bit data).
// Byte-addressed reference memory on the core side, word target on the bus side.
module tb_vm1_qbus_demux;

  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic          pin_clk = 1'b0;
  logic          pin_dclo_n = 1'b0;
  logic [AW-1:0] core_ad_out = '0;
  logic [AW-1:0] core_ad_in;
  logic          core_sync = 1'b0;
  logic          core_din = 1'b0;
  logic          core_dout = 1'b0;
  logic          core_wtbt = 1'b0;
  logic          core_rmw = 1'b0;
  logic          core_rply;
  logic          bus_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_re;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  int tgt_lat = 0;
  int tgt_cnt = 0;
  logic [15:0] tgt_mem [int];
  logic [7:0]  ref_mem [int];

  logic [AW-1:0] seen_addr = '0;
  logic [1:0]    seen_be = '0;
  logic [15:0]   seen_wdata = '0;
  logic          seen_wr = 1'b0;
  int            seen_n = 0;

  vm1_qbus_demux #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TMO_CYC (TMO)
  ) dut (
    .pin_clk     (pin_clk),
    .pin_dclo_n  (pin_dclo_n),
    .core_ad_out (core_ad_out),
    .core_ad_in  (core_ad_in),
    .core_sync   (core_sync),
    .core_din    (core_din),
    .core_dout   (core_dout),
    .core_wtbt   (core_wtbt),
    .core_rmw    (core_rmw),
    .core_rply   (core_rply),
    .bus_err     (bus_err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack)
  );

  always #5 pin_clk = ~pin_clk;

  // Bus target: acks tgt_lat cycles after a request first appears
  always @(negedge pin_clk) begin
    logic [15:0] w;
    int          idx;
    mem_ack = 1'b0;
    if (mem_re || mem_we) begin
      if (tgt_cnt == tgt_lat) begin
        idx        = int'(mem_addr >> 1);
        w          = tgt_mem.exists(idx) ? tgt_mem[idx] : 16'h0000;
        mem_ack    = 1'b1;
        seen_addr  = mem_addr;
        seen_be    = mem_be;
        seen_wdata = mem_wdata;
        seen_wr    = mem_we;
        seen_n++;
        if (mem_re) begin
          mem_rdata = w;
        end else begin
          if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
          if (mem_be[1]) w[15:8] = mem_wdata[15:8];
          tgt_mem[idx] = w;
        end
      end
      tgt_cnt++;
    end else begin
      tgt_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [7:0] ref_byte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [15:0] ref_word(input int a);
    int b;
    b = a - (a % 2);
    return {ref_byte(b + 1), ref_byte(b)};
  endfunction

  task automatic ref_store(input int a, input logic [15:0] d, input logic bt);
    int b;
    b = a - (a % 2);
    if (bt) begin
      ref_mem[a] = 8'(d >> (8 * (a % 2)));
    end else begin
      ref_mem[b]     = d[7:0];
      ref_mem[b + 1] = d[15:8];
    end
  endtask

  task automatic preload(input int a, input logic [15:0] w);
    tgt_mem[a / 2] = w;
    ref_mem[a]     = w[7:0];
    ref_mem[a + 1] = w[15:8];
  endtask

  task automatic addr_phase(input logic [AW-1:0] a, input logic wt, input logic rmw);
    @(negedge pin_clk);
    core_ad_out = a;
    core_wtbt   = wt;
    core_rmw    = rmw;
    core_sync   = 1'b1;
    @(negedge pin_clk);
  endtask

  task automatic rd_phase(input int lat, output int n, output logic [AW-1:0] ad,
                          output logic held, output logic dropped);
    tgt_lat     = lat;
    core_wtbt   = 1'b0;
    core_ad_out = AW'($urandom);
    core_din    = 1'b1;
    n = 0;
    do begin
      @(negedge pin_clk);
      n++;
    end while (!core_rply && n < 60);
    ad = core_ad_in;
    @(negedge pin_clk);
    held     = core_rply;
    core_din = 1'b0;
    @(negedge pin_clk);
    dropped = core_rply;
  endtask

  task automatic wr_phase(input logic [15:0] d, input logic bt, input int lat,
                          output int n, output logic held, output logic dropped);
    tgt_lat     = lat;
    core_ad_out = {6'($urandom), d};
    core_wtbt   = bt;
    core_dout   = 1'b1;
    n = 0;
    do begin
      @(negedge pin_clk);
      n++;
    end while (!core_rply && n < 60);
    @(negedge pin_clk);
    held      = core_rply;
    core_dout = 1'b0;
    @(negedge pin_clk);
    dropped = core_rply;
  endtask

  task automatic end_cycle();
    core_sync = 1'b0;
    core_rmw  = 1'b0;
    core_wtbt = 1'b0;
    @(negedge pin_clk);
    @(negedge pin_clk);
  endtask

  task automatic test_reset();
    pin_dclo_n  = 1'b0;
    core_ad_out = 22'h15555;
    repeat (2) @(negedge pin_clk);
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rst_re: got %b want 0", mem_re); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
    checks++; if (core_rply !== 1'b0) begin errors++; $display("FAIL rst_rply: got %b want 0", core_rply); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus_err); end
    checks++; if (mem_addr !== 22'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_be !== 2'b11) begin errors++; $display("FAIL rst_be: got %b want 11", mem_be); end
    checks++; if (core_ad_in !== 22'h15555) begin errors++; $display("FAIL rst_pass: got %h want 15555", core_ad_in); end
    core_din = 1'b1;
    #1;
    checks++; if (core_ad_in !== 22'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", core_ad_in); end
    core_din   = 1'b0;
    pin_dclo_n = 1'b1;
    @(negedge pin_clk);
  endtask

  task automatic test_word_read();
    int n;
    logic [AW-1:0] ad;
    logic held, dropped;
    preload(32'h1234, 16'hBEEF);
    addr_phase(22'h1234, 1'b0, 1'b0);
    checks++; if (mem_addr !== 22'h1234) begin errors++; $display("FAIL wrd_addr: got %h want 1234", mem_addr); end
    rd_phase(3, n, ad, held, dropped);
    checks++; if (n != 5) begin errors++; $display("FAIL wrd_lat: got %0d want 5", n); end
    checks++; if (ad !== 22'h00BEEF) begin errors++; $display("FAIL wrd_data: got %h want 00beef", ad); end
    checks++; if (seen_be !== 2'b11) begin errors++; $display("FAIL wrd_be: got %b want 11", seen_be); end
    checks++; if (seen_wr !== 1'b0) begin errors++; $display("FAIL wrd_kind: got %b want 0", seen_wr); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL wrd_hold: got %b want 1", held); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL wrd_drop: got %b want 0", dropped); end
    end_cycle();
  endtask

  task automatic test_byte_write();
    int n, n0;
    logic held, dropped;
    n0 = seen_n;
    addr_phase(22'h0101, 1'b1, 1'b0);
    wr_phase(16'h5A00, 1'b1, 0, n, held, dropped);
    ref_store(32'h0101, 16'h5A00, 1'b1);
    checks++; if (n != 2) begin errors++; $display("FAIL bwr_lat: got %0d want 2", n); end
    checks++; if (seen_n - n0 != 1) begin errors++; $display("FAIL bwr_acks: got %0d want 1", seen_n - n0); end
    checks++; if (seen_be !== 2'b10) begin errors++; $display("FAIL bwr_be: got %b want 10", seen_be); end
    checks++; if (seen_wdata !== 16'h5A00) begin errors++; $display("FAIL bwr_wdata: got %h want 5a00", seen_wdata); end
    checks++; if (seen_wr !== 1'b1) begin errors++; $display("FAIL bwr_kind: got %b want 1", seen_wr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bwr_we_drop: got %b want 0", mem_we); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL bwr_drop: got %b want 0", dropped); end
    end_cycle();
  endtask

  task automatic test_rmw();
    int n;
    logic [AW-1:0] ad, ra;
    logic held, dropped, rk;
    preload(32'h2000, 16'h00FF);
    addr_phase(22'h2000, 1'b0, 1'b1);
    rd_phase(1, n, ad, held, dropped);
    ra = seen_addr;
    rk = seen_wr;
    checks++; if (ad !== 22'h0000FF) begin errors++; $display("FAIL rmw_rdata: got %h want 0000ff", ad); end
    checks++; if (rk !== 1'b0) begin errors++; $display("FAIL rmw_rkind: got %b want 0", rk); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL rmw_rdrop: got %b want 0", dropped); end
    wr_phase(16'h0F0F, 1'b0, 0, n, held, dropped);
    ref_store(32'h2000, 16'h0F0F, 1'b0);
    checks++; if (n != 2) begin errors++; $display("FAIL rmw_wlat: got %0d want 2", n); end
    checks++; if (seen_wr !== 1'b1) begin errors++; $display("FAIL rmw_wkind: got %b want 1", seen_wr); end
    checks++; if (seen_addr !== ra) begin errors++; $display("FAIL rmw_addr: got %h want %h", seen_addr, ra); end
    checks++; if (seen_wdata !== 16'h0F0F) begin errors++; $display("FAIL rmw_wdata: got %h want 0f0f", seen_wdata); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL rmw_whold: got %b want 1", held); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL rmw_wdrop: got %b want 0", dropped); end
    end_cycle();
    checks++; if (tgt_mem[32'h1000] !== 16'h0F0F) begin errors++; $display("FAIL rmw_mem: got %h want 0f0f", tgt_mem[32'h1000]); end
  endtask

  task automatic test_addr22();
    int n;
    logic [AW-1:0] ad;
    logic held, dropped;
    preload(32'h3FFFFE, 16'h1357);
    addr_phase(22'h3FFFFE, 1'b0, 1'b0);
    checks++; if (mem_addr !== 22'h3FFFFE) begin errors++; $display("FAIL a22_addr: got %h want 3ffffe", mem_addr); end
    checks++; if (core_ad_in !== 22'h3FFFFE) begin errors++; $display("FAIL a22_pass: got %h want 3ffffe", core_ad_in); end
    rd_phase(1, n, ad, held, dropped);
    checks++; if (ad !== 22'h001357) begin errors++; $display("FAIL a22_rdata: got %h want 001357", ad); end
    checks++; if (n != 3) begin errors++; $display("FAIL a22_lat: got %0d want 3", n); end
    end_cycle();
  endtask

  task automatic test_timeout();
    int n;
    logic rp, be;
    addr_phase(22'h0040, 1'b0, 1'b0);
    tgt_lat  = 100000;
    core_din = 1'b1;
`ifdef VM1_QBUS_TIMEOUT_EN
    n = 0;
    do begin
      @(negedge pin_clk);
      n++;
    end while (!core_rply && n < 60);
    checks++; if (n != TMO + 1) begin errors++; $display("FAIL tmo_lat: got %0d want %0d", n, TMO + 1); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", bus_err); end
    checks++; if (core_ad_in !== 22'h0) begin errors++; $display("FAIL tmo_rdata: got %h want 0", core_ad_in); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL tmo_re: got %b want 0", mem_re); end
    @(negedge pin_clk);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b want 0", bus_err); end
    checks++; if (core_rply !== 1'b1) begin errors++; $display("FAIL tmo_hold: got %b want 1", core_rply); end
    core_din = 1'b0;
    @(negedge pin_clk);
    end_cycle();
`else
    rp = 1'b0;
    be = 1'b0;
    n  = 0;
    repeat (3 * TMO) begin
      @(negedge pin_clk);
      if (core_rply) rp = 1'b1;
      if (bus_err) be = 1'b1;
    end
    checks++; if (rp !== 1'b0) begin errors++; $display("FAIL tmo_norply: got %b want 0", rp); end
    checks++; if (be !== 1'b0) begin errors++; $display("FAIL tmo_noerr: got %b want 0", be); end
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL tmo_wait: got %b want 1", mem_re); end
    core_sync = 1'b0;
    core_din  = 1'b0;
    @(negedge pin_clk);
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL tmo_abort_re: got %b want 0", mem_re); end
    checks++; if (core_rply !== 1'b0) begin errors++; $display("FAIL tmo_abort_rply: got %b want 0", core_rply); end
    @(negedge pin_clk);
`endif
    tgt_lat = 0;
  endtask

  task automatic test_reset_mid_write();
    int n;
    logic [AW-1:0] ad;
    logic held, dropped;
    addr_phase(22'h0300, 1'b1, 1'b0);
    tgt_lat     = 100000;
    core_ad_out = 22'h00A5A5;
    core_dout   = 1'b1;
    repeat (2) @(negedge pin_clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rmid_we: got %b want 1", mem_we); end
    pin_dclo_n = 1'b0;
    @(negedge pin_clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we0: got %b want 0", mem_we); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rmid_re0: got %b want 0", mem_re); end
    checks++; if (core_rply !== 1'b0) begin errors++; $display("FAIL rmid_rply: got %b want 0", core_rply); end
    checks++; if (mem_addr !== 22'h0) begin errors++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rmid_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_be !== 2'b11) begin errors++; $display("FAIL rmid_be: got %b want 11", mem_be); end
    core_din = 1'b1;
    #1;
    checks++; if (core_ad_in !== 22'h0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", core_ad_in); end
    core_din   = 1'b0;
    core_dout  = 1'b0;
    core_sync  = 1'b0;
    core_wtbt  = 1'b0;
    pin_dclo_n = 1'b1;
    tgt_lat    = 0;
    @(negedge pin_clk);
    addr_phase(22'h0302, 1'b1, 1'b0);
    wr_phase(16'h1111, 1'b0, 0, n, held, dropped);
    ref_store(32'h0302, 16'h1111, 1'b0);
    checks++; if (n != 2) begin errors++; $display("FAIL rmid_wlat: got %0d want 2", n); end
    end_cycle();
    addr_phase(22'h0302, 1'b0, 1'b0);
    rd_phase(0, n, ad, held, dropped);
    checks++; if (ad !== 22'h001111) begin errors++; $display("FAIL rmid_rback: got %h want 001111", ad); end
    end_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int kind, lat, a, n;
      logic [15:0] d, exp;
      logic [1:0] ebe;
      logic [AW-1:0] ad;
      logic bt, held, dropped;
      kind = $urandom_range(0, 2);
      lat  = $urandom_range(0, 4);
      a    = 32'h3FFF00 + $urandom_range(0, 31);
      d    = 16'($urandom);
      bt   = (kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!bt) a = a - (a % 2);
      if (kind != 1) begin
        exp = ref_word(a);
        addr_phase(AW'(a), 1'b0, kind == 2);
        checks++; if (mem_addr !== AW'(a)) begin errors++; $display("FAIL rnd_addr: got %h want %h", mem_addr, AW'(a)); end
        rd_phase(lat, n, ad, held, dropped);
        checks++; if (ad !== {6'h0, exp}) begin errors++; $display("FAIL rnd_rdata: got %h want %h", ad, exp); end
        checks++; if (n != 2 + lat) begin errors++; $display("FAIL rnd_rlat: got %0d want %0d", n, 2 + lat); end
        checks++; if (seen_be !== 2'b11) begin errors++; $display("FAIL rnd_rbe: got %b want 11", seen_be); end
        checks++; if (held !== 1'b1 || dropped !== 1'b0) begin errors++; $display("FAIL rnd_rhs: got %b%b want 10", held, dropped); end
      end else begin
        addr_phase(AW'(a), 1'b1, 1'b0);
      end
      if (kind != 0) begin
        lat = $urandom_range(0, 4);
        wr_phase(d, bt, lat, n, held, dropped);
        ref_store(a, d, bt);
        ebe = bt ? 2'(1 << (a % 2)) : 2'b11;
        checks++; if (seen_addr !== AW'(a)) begin errors++; $display("FAIL rnd_waddr: got %h want %h", seen_addr, AW'(a)); end
        checks++; if (seen_be !== ebe) begin errors++; $display("FAIL rnd_wbe: got %b want %b", seen_be, ebe); end
        checks++; if (seen_wdata !== d) begin errors++; $display("FAIL rnd_wdata: got %h want %h", seen_wdata, d); end
        checks++; if (n != 2 + lat) begin errors++; $display("FAIL rnd_wlat: got %0d want %0d", n, 2 + lat); end
        checks++; if (held !== 1'b1 || dropped !== 1'b0) begin errors++; $display("FAIL rnd_whs: got %b%b want 10", held, dropped); end
      end
      end_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_rmw();
    test_addr22();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm1_qbus_demux.md
Name: vm1_qbus_demux

Overview:
- Parametrised bus demultiplexer between the vm1_qbus core's multiplexed AD/SYNC/DIN/DOUT/WTBT/RMW/RPLY handshake and a flat memory/peripheral bus.
- Latches the address when SYNC rises and sequences read, write and read-modify-write (RMW) cycles.
- Generates byte enables and returns RPLY to the core.
- Generalised over address width (16/18/22-bit Q-bus) and data width; adds explicit RMW sequencing and a bus-timeout error path.

Parameters:
- ADDR_W, 16, latched address width (16, 18 or 22).
- DATA_W, 16, data width; multiple of 8.
- TMO_CYC, 64, bus-timeout cycles (used only with the optional feature).

Ports:
- pin_clk  in  1  processor clock.
- pin_dclo_n  in  1  synchronous active-low reset.
- core_ad_out  in  ADDR_W  core AD bus output (address at SYNC, write data in DOUT phase).
- core_ad_in  out  ADDR_W  AD bus back to core: zero-extended rd_data while core_din=1, else core_ad_out.
- core_sync  in  1  address strobe.
- core_din  in  1  read data strobe.
- core_dout  in  1  write data strobe.
- core_wtbt  in  1  write flag in address phase; byte flag in DOUT phase.
- core_rmw  in  1  RMW marker, sampled at SYNC rise.
- core_rply  out  1  reply to core.
- bus_err  out  1  one-cycle timeout pulse.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data.
- mem_re  out  1  read request, held until ack.
- mem_we  out  1  write request, held until ack.
- mem_be  out  DATA_W/8  byte enables.
- mem_ack  in  1  target completion.

Behaviour:
- Reset (pin_dclo_n=0 at a pin_clk edge) forces:
  - state=IDLE;
  - mem_addr, mem_wdata, rd_data = 0;
  - mem_re, mem_we, core_rply, bus_err = 0;
  - mem_be all ones.
- Reset mid-cycle abandons the transaction with no ack wait.
- Edge detection: core_sync, core_din, core_dout are registered once; edges are current vs registered value.

States:
- IDLE: on SYNC rise latch mem_addr=core_ad_out, wr_flag=core_wtbt, rmw_flag=core_rmw; go to ADDR.
- ADDR:
  - core_din=1 -> RD; mem_re=1 next cycle.
  - core_dout=1 -> WR; capture mem_wdata=core_ad_out[DATA_W-1:0] and byte=core_wtbt; mem_we=1 next cycle.
  - core_sync=0 -> IDLE.
- RD: on mem_ack latch rd_data=mem_rdata, drop mem_re, set core_rply=1 -> RDONE.
- RDONE:
  - hold core_rply until core_din falls;
  - then rmw_flag -> RMWW, else -> WAITS.
- RMWW: on core_dout rise capture data and byte -> WR. This path does not require SYNC to re-rise.
- WR: on mem_ack drop mem_we, core_rply=1 -> WDONE.
- WDONE: hold core_rply until core_dout falls -> WAITS.
- WAITS: wait for core_sync=0 -> IDLE.

Rules:
- core_sync falling in any state -> IDLE next cycle; outstanding mem_re/mem_we drop and core_rply=0.
- mem_be:
  - reads: all ones;
  - word writes: all ones;
  - byte writes: one-hot lane mem_addr[log2(DATA_W/8)-1:0]. For DATA_W=16, addr[0]=0 -> 01, 1 -> 10.
  - Byte lanes are not data-shifted; the core already places the byte.
- mem_ack in the same cycle mem_re/mem_we is first driven is accepted: one-cycle target, RPLY visible 2 cycles after DIN/DOUT rise.
- mem_ack outside RD/WR is ignored.
- core_din and core_dout both asserted in ADDR: read wins.

Optional Feature:
- Macro: VM1_QBUS_TIMEOUT_EN.
- With the macro:
  - counter cleared on entry to RD/WR, increments each cycle without mem_ack;
  - at TMO_CYC: pulse bus_err for 1 cycle, drop mem_re/mem_we, assert core_rply (rd_data=0 on reads), proceed as if acked.
- Without the macro: waits indefinitely; bus_err tied 0; no counter logic.

Decomposition:
- Package vm1_qbus_pkg:
  - state enum (IDLE, ADDR, RD, RDONE, RMWW, WR, WDONE, WAITS);
  - function be_gen(byte, addr_lsbs, DATA_W);
  - localparam BE_W = DATA_W/8.
- Sub-module vm1_qbus_edge: 3-signal registered edge detector (rise/fall outputs).

Test Plan:
- Word read, ADDR_W=16: SYNC with ad=0x1234, DIN, ack after 3 cycles, rdata=0xBEEF. Required: mem_addr=0x1234, mem_be=11, core_ad_in=0xBEEF while DIN, core_rply until DIN drop.
- Byte write to odd address 0x0101, wtbt=1 in DOUT, data 0x5A00. Required: mem_we pulse, mem_be=10, mem_wdata=0x5A00.
- RMW at 0x2000: read ack 0x00FF, DIN drop, then DOUT 0x0F0F without SYNC re-rise. Required: mem_re then mem_we, same address, two RPLY handshakes.
- ADDR_W=22: address 0x3FFFFE. Required: mem_addr=0x3FFFFE, core_ad_in upper bits passthrough when not DIN.
- Timeout (macro on, TMO_CYC=8): DIN with no ack. Required: bus_err after 8 cycles, core_rply=1, rd_data=0. With macro off: no rply, bus_err=0.
- pin_dclo_n low during WR with mem_we=1. Required: next cycle all outputs at reset values; subsequent SYNC cycle completes normally.
